serial_addsub6: RTL and testbench

Bit-serial 6-bit two's-complement adder/subtractor that computes a + b or a − b (a + ~b + 1) using a single full-adder cell over WIDTH clock cycles. It sits directly downstream of the combinational 6-bit complement stage: it consumes the same ~b + 1 formulation serially, trading area for latency. It also produces the carry and signed-overflow flags the datapath needs. A start/busy/done handshake frames each operation.

---
 rtl/serial_addsub6.sv | 114 +++++++++++
 tb/tb_serial_addsub6.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub6.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub6
// Brief    : Bit-serial two's-complement add/subtract with carry and overflow
//            flags. One full-adder cell is reused over WIDTH cycles.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub6 #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned c_CW = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_CNT_MSB_IN = c_CW'(WIDTH - 2);
    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [c_CW-1:0]    r_cnt;
    logic               r_cy;
    logic               r_cy_msb_in;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_overflow;

    logic               w_sum;
    logic               w_cout;

    assign w_sum  = r_a[0] ^ r_b[0] ^ r_cy;
    assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_cy) | (r_b[0] & r_cy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_cy        <= 1'b0;
            r_cy_msb_in <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum <= {w_sum, r_sum[WIDTH-1:1]};
                    r_cy  <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_MSB_IN) begin
                        r_cy_msb_in <= w_cout;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        r_result   <= {w_sum, r_sum[WIDTH-1:1]};
                        r_carry    <= w_cout;
                        r_overflow <= r_cy_msb_in ^ w_cout;
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE enables back-to-back ops
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= op ? ~b : b;
                        r_cy    <= op;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub6.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub6
// Brief    : Directed self-checking bench for serial_addsub6.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub6;

    logic       clk;
    logic       rst;
    logic       start;
    logic       op;
    logic [5:0] a;
    logic [5:0] b;
    logic       busy;
    logic       done;
    logic [5:0] result;
    logic       carry;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_addsub6 #(.WIDTH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector table: a, b, op -> result, carry, overflow (hand-computed)
    logic [5:0] va [8] = '{6'b000011, 6'b000000, 6'b000000, 6'b011111,
                           6'b111111, 6'b100000, 6'b000101, 6'b100000};
    logic [5:0] vb [8] = '{6'b000001, 6'b101010, 6'b000001, 6'b000001,
                           6'b000001, 6'b000001, 6'b000111, 6'b111111};
    logic       vop[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [5:0] vr [8] = '{6'b000010, 6'b010110, 6'b111111, 6'b100000,
                           6'b000000, 6'b011111, 6'b001100, 6'b011111};
    logic       vc [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vv [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start pulse and returns cycles until done (-1 on timeout)
    task automatic do_op(input logic [5:0] ia, input logic [5:0] ib,
                         input logic iop, output int lat);
        a = ia; b = ib; op = iop; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        tick(); tick();
        checks++;
        if ({busy, done, result, carry, overflow} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%b carry=%b ovf=%b, want all 0",
                     busy, done, result, carry, overflow);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_arith();
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], vop[i], lat);
            checks++;
            if (lat !== 6) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d, want 6", i, lat);
            end
            checks++;
            if (result !== vr[i]) begin
                errors++;
                $display("FAIL result[%0d]: got %b, want %b", i, result, vr[i]);
            end
            checks++;
            if (carry !== vc[i]) begin
                errors++;
                $display("FAIL carry[%0d]: got %b, want %b", i, carry, vc[i]);
            end
            checks++;
            if (overflow !== vv[i]) begin
                errors++;
                $display("FAIL overflow[%0d]: got %b, want %b", i, overflow, vv[i]);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_width[%0d]: got %b, want 0", i, done);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        // Previous result is 011111/1/1 from the last table vector
        a = 6'b000011; b = 6'b000001; op = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, want 1", busy);
        end
        tick();
        a = 6'b000000; b = 6'b000001; op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (result !== 6'b011111 || carry !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL hold_during_run: got %b/%b/%b, want 011111/1/1",
                     result, carry, overflow);
        end
        lat = -1;
        for (int n = 3; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL ignore_latency: got %0d, want 6", lat);
        end
        checks++;
        if (result !== 6'b000010 || carry !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: got %b/%b/%b, want 000010/1/0",
                     result, carry, overflow);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int  lat;
        int  gap;
        logic stable_ok;
        a = 6'b011111; b = 6'b000001; op = 1'b0; start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d, want 7", lat);
        end
        checks++;
        if (result !== 6'b100000 || carry !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_result: got %b/%b/%b, want 100000/0/1",
                     result, carry, overflow);
        end
        a = 6'b111111; b = 6'b000001; op = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_idle: got busy=%b, want 1", busy);
        end
        a = 6'b000000; b = 6'b000000;
        gap = -1;
        stable_ok = (result === 6'b100000);
        for (int n = 2; n <= 20; n++) begin
            tick();
            if (done) begin
                gap = n;
                break;
            end
            if (result !== 6'b100000) stable_ok = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (!stable_ok) begin
            errors++;
            $display("FAIL b2b_stable: got result changes between done pulses, want 100000 held");
        end
        checks++;
        if (gap !== 7) begin
            errors++;
            $display("FAIL b2b_period: got %0d, want 7", gap);
        end
        checks++;
        if (result !== 6'b000000 || carry !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_result: got %b/%b/%b, want 000000/1/0",
                     result, carry, overflow);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        a = 6'b100000; b = 6'b000001; op = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, carry, overflow} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b result=%b carry=%b ovf=%b, want all 0",
                     busy, done, result, carry, overflow);
        end
        #3 rst = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got done/busy activity after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
